// File: rtl/sram_arbiter_if.sv
// -----------------------------------------------------------------------------
// sram_arbiter_if
// Bundles the pipeline-side request/ack signals and the SRAM-side bus of the
// IF/MEM SRAM arbiter.
//   slave  : arbiter view (takes requests and SRAM responses, drives acks,
//            read data, stall requests and the SRAM strobe/address/data)
//   master : requester/SRAM-model view (the mirror image)
// Signals:
//   if_req/if_addr/if_ack/if_rdata                  instruction fetch port
//   mem_req/mem_we/mem_sel/mem_addr/mem_wdata/
//   mem_ack/mem_rdata                               load/store port
//   bus_err                                         timeout flag, valid with ack
//   sram_ce/sram_we/sram_sel/sram_addr/sram_wdata/
//   sram_rdata/sram_ready                           single-port SRAM bus
//   stallreq_from_if/stallreq_from_mem              stall requests to ctrl
// -----------------------------------------------------------------------------
interface sram_arbiter_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_ack;
   logic [31:0] if_rdata;
   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_sel;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        bus_err;
   logic        sram_ce;
   logic        sram_we;
   logic [3:0]  sram_sel;
   logic [31:0] sram_addr;
   logic [31:0] sram_wdata;
   logic [31:0] sram_rdata;
   logic        sram_ready;
   logic        stallreq_from_if;
   logic        stallreq_from_mem;

   modport slave (
      input  if_req, if_addr, mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
             sram_rdata, sram_ready,
      output if_ack, if_rdata, mem_ack, mem_rdata, bus_err,
             sram_ce, sram_we, sram_sel, sram_addr, sram_wdata,
             stallreq_from_if, stallreq_from_mem
   );

   modport master (
      output if_req, if_addr, mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
             sram_rdata, sram_ready,
      input  if_ack, if_rdata, mem_ack, mem_rdata, bus_err,
             sram_ce, sram_we, sram_sel, sram_addr, sram_wdata,
             stallreq_from_if, stallreq_from_mem
   );
endinterface

// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
// Shares one single-port SRAM between the IF stage (word fetch) and the MEM
// stage (load/store). Each access runs IDLE -> BUSY -> DONE; DONE carries a
// one-cycle ack with read data. An access that sees no sram_ready for
// TIMEOUT-1 BUSY cycles is aborted with bus_err=1 and rdata=0.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  sram_arbiter_if.slave (request ports, SRAM bus, acks, stalls)
// Parameters:
//   TIMEOUT  BUSY cycles (+1) tolerated without sram_ready, >= 2
//   TO_W     wait counter width, must hold TIMEOUT
// -----------------------------------------------------------------------------
module sram_arbiter #(
   parameter int TIMEOUT = 16,
   parameter int TO_W    = 5
) (
   input logic           clk,
   input logic           rst,
   sram_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Abort fires in the BUSY cycle where the counter would reach TIMEOUT-1.
   localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 2);

   state_t          state_r, state_s;
   logic            owner_mem_r, owner_mem_s;
   logic            last_mem_r, last_mem_s;
   logic [TO_W-1:0] cnt_r, cnt_s;
   logic            ce_r, ce_s;
   logic            we_r, we_s;
   logic [3:0]      sel_r, sel_s;
   logic [31:0]     addr_r, addr_s;
   logic [31:0]     wdata_r, wdata_s;
   logic            if_ack_r, if_ack_s;
   logic            mem_ack_r, mem_ack_s;
   logic            bus_err_r, bus_err_s;
   logic [31:0]     if_rdata_r, if_rdata_s;
   logic [31:0]     mem_rdata_r, mem_rdata_s;
   logic            grant_mem_s;
   logic [31:0]     rsp_data_s;

   // MEM wins a tie unless it was served last; a lone request always wins.
   assign grant_mem_s = bus.mem_req & (~bus.if_req | ~last_mem_r);
   // A timed-out access returns zero data.
   assign rsp_data_s  = bus.sram_ready ? bus.sram_rdata : 32'h0000_0000;

   // Next-state and next-register-value logic.
   always_comb begin
      state_s     = state_r;
      owner_mem_s = owner_mem_r;
      last_mem_s  = last_mem_r;
      cnt_s       = cnt_r;
      ce_s        = ce_r;
      we_s        = we_r;
      sel_s       = sel_r;
      addr_s      = addr_r;
      wdata_s     = wdata_r;
      if_ack_s    = 1'b0;
      mem_ack_s   = 1'b0;
      bus_err_s   = bus_err_r;
      if_rdata_s  = if_rdata_r;
      mem_rdata_s = mem_rdata_r;
      case (state_r)
         S_IDLE: begin
            bus_err_s = 1'b0;
            if (bus.if_req || bus.mem_req) begin
               owner_mem_s = grant_mem_s;
               ce_s        = 1'b1;
               cnt_s       = '0;
               state_s     = S_BUSY;
               if (grant_mem_s) begin
                  we_s    = bus.mem_we;
                  sel_s   = bus.mem_sel;
                  addr_s  = bus.mem_addr;
                  wdata_s = bus.mem_wdata;
               end else begin
                  we_s    = 1'b0;
                  sel_s   = 4'b1111;
                  addr_s  = bus.if_addr;
                  wdata_s = 32'h0000_0000;
               end
            end else begin
               state_s = S_IDLE;
            end
         end
         S_BUSY: begin
            if (bus.sram_ready || (cnt_r == CNT_LAST)) begin
               ce_s      = 1'b0;
               bus_err_s = ~bus.sram_ready;
               state_s   = S_DONE;
               if (owner_mem_r) begin
                  mem_ack_s   = 1'b1;
                  mem_rdata_s = rsp_data_s;
               end else begin
                  if_ack_s   = 1'b1;
                  if_rdata_s = rsp_data_s;
               end
            end else begin
               cnt_s   = cnt_r + TO_W'(1);
               state_s = S_BUSY;
            end
         end
         S_DONE: begin
            // bus_err is visible only alongside the ack.
            last_mem_s = owner_mem_r;
            bus_err_s  = 1'b0;
            state_s    = S_IDLE;
         end
         default: begin
            ce_s    = 1'b0;
            state_s = S_IDLE;
         end
      endcase
   end

   // State and registered-output update; reset drops sram_ce immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= S_IDLE;
         owner_mem_r <= 1'b0;
         last_mem_r  <= 1'b0;
         cnt_r       <= '0;
         ce_r        <= 1'b0;
         we_r        <= 1'b0;
         sel_r       <= 4'b0000;
         addr_r      <= 32'h0000_0000;
         wdata_r     <= 32'h0000_0000;
         if_ack_r    <= 1'b0;
         mem_ack_r   <= 1'b0;
         bus_err_r   <= 1'b0;
         if_rdata_r  <= 32'h0000_0000;
         mem_rdata_r <= 32'h0000_0000;
      end else begin
         state_r     <= state_s;
         owner_mem_r <= owner_mem_s;
         last_mem_r  <= last_mem_s;
         cnt_r       <= cnt_s;
         ce_r        <= ce_s;
         we_r        <= we_s;
         sel_r       <= sel_s;
         addr_r      <= addr_s;
         wdata_r     <= wdata_s;
         if_ack_r    <= if_ack_s;
         mem_ack_r   <= mem_ack_s;
         bus_err_r   <= bus_err_s;
         if_rdata_r  <= if_rdata_s;
         mem_rdata_r <= mem_rdata_s;
      end
   end

   assign bus.sram_ce    = ce_r;
   assign bus.sram_we    = we_r;
   assign bus.sram_sel   = sel_r;
   assign bus.sram_addr  = addr_r;
   assign bus.sram_wdata = wdata_r;
   assign bus.if_ack     = if_ack_r;
   assign bus.mem_ack    = mem_ack_r;
   assign bus.bus_err    = bus_err_r;
   assign bus.if_rdata   = if_rdata_r;
   assign bus.mem_rdata  = mem_rdata_r;

   // Acks are registered, so the stall drops cleanly in the ack cycle.
   assign bus.stallreq_from_if  = bus.if_req  & ~if_ack_r;
   assign bus.stallreq_from_mem = bus.mem_req & ~mem_ack_r;

endmodule

// File: tb/tb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter
// Transaction-level reference: each grant is scheduled as a window of cycles
// (grant cycle g, SRAM strobe g+1..ack-1, ack, next IDLE) from the arbitration
// rule and the SRAM wait count the bench itself chooses. A negedge process
// compares every output each cycle; directed scenarios pin exact cycles.
// -----------------------------------------------------------------------------
module tb_sram_arbiter;
   localparam int TIMEOUT = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;

   sram_arbiter_if bus();

   sram_arbiter #(.TIMEOUT(TIMEOUT), .TO_W(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // stimulus control
   bit          rst_next  = 1'b1;
   bit          auto_req  = 1'b0;
   bit          run_chk   = 1'b0;
   int          force_w   = -1;
   logic        d_if_req  = 1'b0;
   logic [31:0] d_if_addr = 32'h0;
   logic        d_mem_req = 1'b0;
   logic        d_mem_we  = 1'b0;
   logic [3:0]  d_mem_sel = 4'h0;
   logic [31:0] d_mem_addr  = 32'h0;
   logic [31:0] d_mem_wdata = 32'h0;
   bit          if_acked_prev  = 1'b0;
   bit          mem_acked_prev = 1'b0;

   // reference model: one scheduled transaction at a time
   int          free_c = 1, g_c = -100, ack_c = -100, ready_c = -1;
   bit          to_m = 1'b0, own_mem = 1'b0, last_mem_m = 1'b0;
   logic [31:0] t_addr = 32'h0, t_wdata = 32'h0, cap_rdata = 32'h0;
   logic        t_we = 1'b0;
   logic [3:0]  t_sel = 4'h0;
   logic [31:0] exp_if_rdata = 32'h0, exp_mem_rdata = 32'h0;
   bit          mem_rdata_known = 1'b1;
   bit          exp_ce = 1'b0, exp_if_ack = 1'b0, exp_mem_ack = 1'b0, exp_err = 1'b0;

   // samples taken by the compare process
   logic        smp_ce, smp_we, smp_if_ack, smp_mem_ack, smp_err, smp_st_if, smp_st_mem;
   logic [3:0]  smp_sel;
   logic [31:0] smp_addr, smp_wdata, smp_if_rdata, smp_mem_rdata;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
      end
   endtask

   // One clock cycle: drive inputs just after the edge, advance the model,
   // then wait until the compare process has sampled this cycle.
   task automatic step();
      int w;
      int b;
      logic [31:0] val;
      @(posedge clk);
      #1;
      cyc++;
      rst = rst_next;
      if (auto_req) begin
         if (!bus.if_req || if_acked_prev) begin
            bus.if_req  = ($urandom_range(0, 2) != 0);
            bus.if_addr = $urandom;
         end
         if (!bus.mem_req || mem_acked_prev) begin
            bus.mem_req   = ($urandom_range(0, 2) != 0);
            bus.mem_we    = $urandom_range(0, 1);
            bus.mem_sel   = 4'($urandom_range(0, 15));
            bus.mem_addr  = $urandom;
            bus.mem_wdata = $urandom;
         end
      end else begin
         bus.if_req    = d_if_req;
         bus.if_addr   = d_if_addr;
         bus.mem_req   = d_mem_req;
         bus.mem_we    = d_mem_we;
         bus.mem_sel   = d_mem_sel;
         bus.mem_addr  = d_mem_addr;
         bus.mem_wdata = d_mem_wdata;
      end
      if_acked_prev  = 1'b0;
      mem_acked_prev = 1'b0;

      if (rst) begin
         free_c = cyc + 1; g_c = -100; ack_c = -100; ready_c = -1;
         to_m = 1'b0; last_mem_m = 1'b0;
         exp_if_rdata = 32'h0; exp_mem_rdata = 32'h0; mem_rdata_known = 1'b1;
      end else if (cyc == free_c) begin
         if (bus.if_req || bus.mem_req) begin
            own_mem    = bus.mem_req && (!bus.if_req || !last_mem_m);
            last_mem_m = own_mem;
            t_addr  = own_mem ? bus.mem_addr : bus.if_addr;
            t_we    = own_mem ? bus.mem_we : 1'b0;
            t_sel   = own_mem ? bus.mem_sel : 4'hF;
            t_wdata = bus.mem_wdata;
            if (force_w >= 0) w = force_w;
            else if ($urandom_range(0, 7) == 0) w = $urandom_range(TIMEOUT - 2, TIMEOUT + 1);
            else w = $urandom_range(0, 3);
            to_m    = (w + 1 > TIMEOUT - 1);
            b       = to_m ? TIMEOUT - 1 : w + 1;
            g_c     = cyc;
            ready_c = to_m ? -1 : g_c + 1 + w;
            ack_c   = g_c + b + 1;
            free_c  = ack_c + 1;
         end else begin
            free_c = cyc + 1;
         end
      end

      bus.sram_rdata = auto_req ? $urandom : 32'h1234_5678;
      if (cyc > g_c && cyc < ack_c) bus.sram_ready = (cyc == ready_c);
      else bus.sram_ready = $urandom_range(0, 1);
      if (cyc == ready_c) cap_rdata = bus.sram_rdata;

      exp_ce      = (cyc > g_c) && (cyc < ack_c);
      exp_if_ack  = (cyc == ack_c) && !own_mem;
      exp_mem_ack = (cyc == ack_c) && own_mem;
      exp_err     = (cyc == ack_c) && to_m;
      if (cyc == ack_c) begin
         val = to_m ? 32'h0 : cap_rdata;
         if (own_mem) begin
            mem_acked_prev = 1'b1;
            if (t_we) mem_rdata_known = 1'b0;
            else begin exp_mem_rdata = val; mem_rdata_known = 1'b1; end
         end else begin
            if_acked_prev = 1'b1;
            exp_if_rdata  = val;
         end
      end
      @(negedge clk);
      #1;
   endtask

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      smp_ce = bus.sram_ce; smp_we = bus.sram_we; smp_sel = bus.sram_sel;
      smp_addr = bus.sram_addr; smp_wdata = bus.sram_wdata;
      smp_if_ack = bus.if_ack; smp_mem_ack = bus.mem_ack; smp_err = bus.bus_err;
      smp_if_rdata = bus.if_rdata; smp_mem_rdata = bus.mem_rdata;
      smp_st_if = bus.stallreq_from_if; smp_st_mem = bus.stallreq_from_mem;
      if (run_chk) begin
         chk("sram_ce", smp_ce, exp_ce);
         if (exp_ce) begin
            chk("sram_addr", smp_addr, t_addr);
            chk("sram_we", smp_we, t_we);
            chk("sram_sel", smp_sel, t_sel);
            if (t_we) chk("sram_wdata", smp_wdata, t_wdata);
         end
         chk("if_ack", smp_if_ack, exp_if_ack);
         chk("mem_ack", smp_mem_ack, exp_mem_ack);
         chk("bus_err", smp_err, exp_err);
         chk("if_rdata", smp_if_rdata, exp_if_rdata);
         if (mem_rdata_known) chk("mem_rdata", smp_mem_rdata, exp_mem_rdata);
         chk("stall_if", smp_st_if, bus.if_req & ~exp_if_ack);
         chk("stall_mem", smp_st_mem, bus.mem_req & ~exp_mem_ack);
      end
   end

   initial begin
      int ack_seq[$];
      bus.if_req = 1'b0; bus.if_addr = 32'h0; bus.mem_req = 1'b0; bus.mem_we = 1'b0;
      bus.mem_sel = 4'h0; bus.mem_addr = 32'h0; bus.mem_wdata = 32'h0;
      bus.sram_rdata = 32'h0; bus.sram_ready = 1'b0;

      repeat (3) step();
      run_chk = 1'b1;
      step();
      chk("reset_ce", smp_ce, 1'b0);
      chk("reset_if_rdata", smp_if_rdata, 32'h0);

      // fetch at 0x100 with a zero-wait SRAM
      rst_next = 1'b0; d_if_req = 1'b1; d_if_addr = 32'h100; force_w = 0;
      step();
      chk("t1_c0_ce", smp_ce, 1'b0);
      chk("t1_c0_stall", smp_st_if, 1'b1);
      step();
      chk("t1_c1_ce", smp_ce, 1'b1);
      chk("t1_c1_addr", smp_addr, 32'h100);
      chk("t1_c1_sel", smp_sel, 4'hF);
      chk("t1_c1_stall", smp_st_if, 1'b1);
      step();
      chk("t1_c2_ack", smp_if_ack, 1'b1);
      chk("t1_c2_rdata", smp_if_rdata, 32'h1234_5678);
      chk("t1_c2_stall", smp_st_if, 1'b0);
      d_if_req = 1'b0;
      step();
      chk("t1_c3_ack", smp_if_ack, 1'b0);

      // both held high: MEM, IF, MEM
      d_if_req = 1'b1; d_if_addr = 32'h400;
      d_mem_req = 1'b1; d_mem_we = 1'b0; d_mem_sel = 4'hF; d_mem_addr = 32'h800;
      for (int i = 0; i < 9; i++) begin
         step();
         if (smp_mem_ack) ack_seq.push_back(i);
         if (smp_if_ack)  ack_seq.push_back(100 + i);
      end
      chk("t2_ack_count", ack_seq.size(), 3);
      if (ack_seq.size() == 3) begin
         chk("t2_first_mem", ack_seq[0], 2);
         chk("t2_then_if", ack_seq[1], 105);
         chk("t2_then_mem", ack_seq[2], 8);
      end
      d_if_req = 1'b0; d_mem_req = 1'b0;
      step();

      // store with partial byte enables
      d_mem_req = 1'b1; d_mem_we = 1'b1; d_mem_sel = 4'b0011;
      d_mem_addr = 32'h200; d_mem_wdata = 32'hDEAD_BEEF;
      step();
      step();
      chk("t3_we", smp_we, 1'b1);
      chk("t3_sel", smp_sel, 4'b0011);
      chk("t3_wdata", smp_wdata, 32'hDEAD_BEEF);
      step();
      chk("t3_ack", smp_mem_ack, 1'b1);
      d_mem_req = 1'b0;
      step();
      chk("t3_ack_pulse", smp_mem_ack, 1'b0);

      // timeout: no sram_ready, ack at cycle TIMEOUT with bus_err
      d_if_req = 1'b1; d_if_addr = 32'h300; force_w = TIMEOUT + 2;
      step();
      for (int i = 1; i <= TIMEOUT; i++) begin
         step();
         if (i == TIMEOUT - 1) begin
            chk("t4_ce_last", smp_ce, 1'b1);
            chk("t4_no_early_ack", smp_if_ack, 1'b0);
         end
      end
      chk("t4_ack", smp_if_ack, 1'b1);
      chk("t4_err", smp_err, 1'b1);
      chk("t4_rdata0", smp_if_rdata, 32'h0);
      d_if_req = 1'b0; d_mem_req = 1'b1; d_mem_we = 1'b0; d_mem_sel = 4'hF;
      d_mem_addr = 32'h500; force_w = 0;
      step(); step(); step();
      chk("t4_next_ack", smp_mem_ack, 1'b1);
      chk("t4_next_err", smp_err, 1'b0);
      d_mem_req = 1'b0;
      step();

      // SRAM three wait cycles: ack at cycle 5
      d_if_req = 1'b1; d_if_addr = 32'h600; force_w = 3;
      for (int i = 0; i <= 5; i++) begin
         step();
         if (i < 5) chk("t6_stall", smp_st_if, 1'b1);
      end
      chk("t6_ack", smp_if_ack, 1'b1);
      d_if_req = 1'b0;
      step();

      // reset in the middle of BUSY; pending load is re-granted afterwards
      d_mem_req = 1'b1; d_mem_we = 1'b0; d_mem_addr = 32'h700; force_w = TIMEOUT + 2;
      step(); step();
      chk("t5_ce_before", smp_ce, 1'b1);
      rst_next = 1'b1;
      step();
      chk("t5_ce_dropped", smp_ce, 1'b0);
      chk("t5_no_ack", smp_mem_ack, 1'b0);
      step();
      rst_next = 1'b0; force_w = 0;
      step(); step(); step();
      chk("t5_regrant_ack", smp_mem_ack, 1'b1);
      d_mem_req = 1'b0;
      step();

      // randomized traffic with one reset in the middle
      force_w = -1; auto_req = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         rst_next = (i >= 1500 && i < 1502);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
